// File: rtl/title_text_sequencer_pkg.sv
// Shared types and geometry constants for the "NEW GAME" title text sequencer.
// Also holds the glyph bit extraction helper used by the pixel pipeline.
package title_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REVEAL = 2'd1,
        BLINK  = 2'd2
    } title_state_t;

    localparam int GLYPH_W     = 20;
    localparam int GLYPH_H     = 20;
    localparam int GLYPH_BITS  = GLYPH_W * GLYPH_H;
    localparam int PITCH_LOG2  = 5;
    localparam int NUM_LETTERS = 8;
    localparam int SLOT_W      = $clog2(NUM_LETTERS);
    localparam int BOX_W       = 256;
    localparam int COORD_W     = 10;

    // Row 0 col 0 lives in the MSB; coordinates outside the glyph read as dark.
    function automatic logic glyph_bit(input logic [GLYPH_BITS-1:0] bits,
                                       input logic [4:0] row,
                                       input logic [4:0] col);
        logic [9:0] idx;
        idx = 10'(row) * 10'(GLYPH_W) + 10'(col);
        if (row < 5'(GLYPH_H) && col < 5'(GLYPH_W))
            return bits[10'(GLYPH_BITS - 1) - idx];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/title_text_sequencer_if.sv
// Pixel stream, glyph ROM and control handshake between the VGA side and the sequencer.
// The master side drives coordinates, ROM data and controls; the slave side is the sequencer.
interface title_text_sequencer_if;
    logic         enable;
    logic         frame_start;
    logic         start_pressed;
    logic [9:0]   pixel_x;
    logic [9:0]   pixel_y;
    logic [3:0]   selected_letter;
    logic [399:0] letter_bits;
    logic         pixel_on;
    logic         game_start;
    logic         busy;

    modport master (
        output enable, frame_start, start_pressed, pixel_x, pixel_y, letter_bits,
        input  selected_letter, pixel_on, game_start, busy
    );

    modport slave (
        input  enable, frame_start, start_pressed, pixel_x, pixel_y, letter_bits,
        output selected_letter, pixel_on, game_start, busy
    );
endinterface

// File: rtl/title_text_sequencer_frame_tick_counter.sv
// Counts frame_start pulses and fires a combinational tick on the Nth one, restarting at zero.
// clear dominates and also suppresses the tick so a leaving state never sees a stale step.
module frame_tick_counter #(
    parameter int N = 1
) (
    input  logic clock_25,
    input  logic reset,
    input  logic clear,
    input  logic frame_start,
    output logic tick
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == CW'(N - 1));
    assign tick   = frame_start & ~clear & w_last;

    always_ff @(posedge clock_25) begin
        if (reset || clear)
            r_count <= '0;
        else if (frame_start)
            r_count <= w_last ? '0 : r_count + 1'b1;
    end
endmodule

// File: rtl/title_text_sequencer.sv
// Title text sequencer: maps VGA pixels onto the 8-slot glyph box, runs a 3-stage pixel pipeline
// around the registered glyph ROM, and sequences letter reveal, blink and game handoff.
module title_text_sequencer
    import title_pkg::*;
#(
    parameter int X0            = 192,
    parameter int Y0            = 230,
    parameter int REVEAL_FRAMES = 15,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic                  clock_25,
    input  logic                  reset,
    title_text_sequencer_if.slave bus
);

    title_state_t r_state;
    logic [3:0]   r_revealed;
    logic         r_blink_vis;
    logic         r_game_start;
    logic         r_busy;
    logic         r_start_prev;

    logic [COORD_W-1:0] w_relx;
    logic [COORD_W-1:0] w_rely;
    logic               w_inside;
    logic [SLOT_W-1:0]  w_slot;
    logic [4:0]         w_col;
    logic [4:0]         w_row;
    logic               w_visible;
    logic               w_glyph_bit;

    logic [3:0] r_selected_letter;
    logic [4:0] r_row1, r_col1, r_row2, r_col2;
    logic       r_inside1, r_inside2;
    logic       r_vis1, r_vis2;
    logic       r_pixel_on;

    logic w_start_edge;
    logic w_reveal_clear, w_blink_clear;
    logic w_counted_frame;
    logic w_reveal_tick, w_blink_tick;

    // Unsigned wrap makes pixels left of or above the box land far outside it.
    assign w_relx    = bus.pixel_x - COORD_W'(X0);
    assign w_rely    = bus.pixel_y - COORD_W'(Y0);
    assign w_col     = w_relx[PITCH_LOG2-1:0];
    assign w_row     = w_rely[4:0];
    assign w_slot    = w_relx[PITCH_LOG2+SLOT_W-1:PITCH_LOG2];
    assign w_inside  = (w_relx < COORD_W'(BOX_W)) && (w_col < 5'(GLYPH_W))
                     && (w_rely < COORD_W'(GLYPH_H));
    assign w_visible = ({1'b0, w_slot} < r_revealed) && r_blink_vis;

    assign w_glyph_bit = glyph_bit(bus.letter_bits, r_row2, r_col2);

    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_selected_letter <= '0;
            r_row1            <= '0;
            r_col1            <= '0;
            r_inside1         <= 1'b0;
            r_vis1            <= 1'b0;
            r_row2            <= '0;
            r_col2            <= '0;
            r_inside2         <= 1'b0;
            r_vis2            <= 1'b0;
            r_pixel_on        <= 1'b0;
        end else begin
            if (w_inside)
                r_selected_letter <= {1'b0, w_slot};
            r_row1     <= w_row;
            r_col1     <= w_col;
            r_inside1  <= w_inside;
            r_vis1     <= w_visible;
            r_row2     <= r_row1;
            r_col2     <= r_col1;
            r_inside2  <= r_inside1;
            r_vis2     <= r_vis1;
            r_pixel_on <= r_inside2 & r_vis2 & w_glyph_bit;
        end
    end

    assign w_start_edge = bus.start_pressed & ~r_start_prev;

    always_ff @(posedge clock_25) begin
        if (reset)
            r_start_prev <= 1'b0;
        else
            r_start_prev <= bus.start_pressed;
    end

    // A frame_start that lands on a start edge must not advance either counter.
    assign w_counted_frame = bus.frame_start & ~w_start_edge;
    assign w_reveal_clear  = (r_state != REVEAL) | ~bus.enable;
    assign w_blink_clear   = (r_state != BLINK)  | ~bus.enable;

    frame_tick_counter #(.N(REVEAL_FRAMES)) u_reveal_counter (
        .clock_25    (clock_25),
        .reset       (reset),
        .clear       (w_reveal_clear),
        .frame_start (w_counted_frame),
        .tick        (w_reveal_tick)
    );

    frame_tick_counter #(.N(BLINK_FRAMES)) u_blink_counter (
        .clock_25    (clock_25),
        .reset       (reset),
        .clear       (w_blink_clear),
        .frame_start (w_counted_frame),
        .tick        (w_blink_tick)
    );

    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_state      <= IDLE;
            r_revealed   <= '0;
            r_blink_vis  <= 1'b1;
            r_game_start <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_game_start <= 1'b0;
            if (!bus.enable) begin
                r_state     <= IDLE;
                r_revealed  <= '0;
                r_blink_vis <= 1'b1;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state     <= REVEAL;
                        r_revealed  <= '0;
                        r_blink_vis <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                    REVEAL: begin
                        if (w_start_edge) begin
                            r_state     <= BLINK;
                            r_revealed  <= 4'(NUM_LETTERS);
                            r_blink_vis <= 1'b1;
                        end else if (w_reveal_tick) begin
                            r_revealed <= r_revealed + 1'b1;
                            if (r_revealed == 4'(NUM_LETTERS - 1))
                                r_state <= BLINK;
                        end
                    end
                    BLINK: begin
                        if (w_start_edge) begin
                            r_state      <= IDLE;
                            r_revealed   <= '0;
                            r_blink_vis  <= 1'b1;
                            r_game_start <= 1'b1;
                            r_busy       <= 1'b0;
                        end else if (w_blink_tick) begin
                            r_blink_vis <= ~r_blink_vis;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.selected_letter = r_selected_letter;
    assign bus.pixel_on        = r_pixel_on;
    assign bus.game_start      = r_game_start;
    assign bus.busy            = r_busy;

endmodule

// File: tb/tb_title_text_sequencer.sv
// Self-checking bench for title_text_sequencer: glyph ROM model, pixel scoreboard with
// 3-cycle latency, a geometry vector table and hand-written reveal/blink/handoff/abort sequences.
module tb_title_text_sequencer;

    typedef struct {
        int    x;
        int    y;
        logic  exp;
        string name;
    } pixVec_t;

    typedef struct {
        logic  exp;
        string name;
        int    due;
    } sbEntry_t;

    logic         clock_25;
    logic         reset;
    logic [399:0] rom [8];
    int           compareCount;
    int           mismatchCount;
    int           cycleCount;
    sbEntry_t     sb [$];
    sbEntry_t     sbHead;
    pixVec_t      geomVec [$];
    logic         sawGameStart;

    title_text_sequencer_if bus ();

    title_text_sequencer #(
        .X0            (192),
        .Y0            (230),
        .REVEAL_FRAMES (2),
        .BLINK_FRAMES  (3)
    ) dut (
        .clock_25 (clock_25),
        .reset    (reset),
        .bus      (bus)
    );

    initial clock_25 = 1'b0;
    always #20 clock_25 = ~clock_25;

    always @(posedge clock_25) cycleCount++;

    // Glyphs are drawn in cols 0..17 only, so col 19 of every glyph is dark; slot 3 is blank.
    function automatic logic glyphLit(int k, int r, int c);
        if (k == 3 || c >= 18)
            return 1'b0;
        return (c == 0) || (((r + c + k) % 3) == 0);
    endfunction

    always @(posedge clock_25) bus.letter_bits <= rom[bus.selected_letter[2:0]];

    always @(negedge clock_25) begin
        if (sb.size() > 0 && sb[0].due == cycleCount) begin
            sbHead = sb.pop_front();
            compareCount++;
            if (bus.pixel_on !== sbHead.exp) begin
                mismatchCount++;
                $display("[TB] FAIL %s: pixel_on got %b want %b", sbHead.name, bus.pixel_on, sbHead.exp);
            end
        end
    end

    task automatic checkOutput(string name, logic [31:0] got, logic [31:0] want);
        compareCount++;
        if (got !== want) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic applyStimulus(int x, int y, logic exp, string name);
        sbEntry_t e;
        @(negedge clock_25);
        bus.pixel_x = 10'(x);
        bus.pixel_y = 10'(y);
        e.exp  = exp;
        e.name = name;
        e.due  = cycleCount + 3;
        sb.push_back(e);
    endtask

    task automatic drainScoreboard();
        repeat (4) @(negedge clock_25);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic pulseFrame(int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clock_25);
            bus.frame_start = 1'b1;
            @(negedge clock_25);
            bus.frame_start = 1'b0;
        end
    endtask

    task automatic addVec(int x, int y, logic e, string n);
        pixVec_t v;
        v.x = x;
        v.y = y;
        v.exp = e;
        v.name = n;
        geomVec.push_back(v);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        cycleCount    = 0;
        for (int k = 0; k < 8; k++)
            for (int r = 0; r < 20; r++)
                for (int c = 0; c < 20; c++)
                    rom[k][399 - (r * 20 + c)] = glyphLit(k, r, c);

        addVec(192, 230, 1'b1, "geom_n_origin");
        addVec(211, 230, 1'b0, "geom_n_col19");
        addVec(212, 230, 1'b0, "geom_gap");
        addVec(448, 230, 1'b0, "geom_relx_256");
        addVec(192, 250, 1'b0, "geom_rely_20");
        addVec(191, 230, 1'b0, "geom_relx_wrap");
        addVec(224, 230, 1'b1, "geom_e_origin");
        addVec(288, 230, 1'b0, "geom_blank_slot3");
        addVec(193, 231, 1'b0, "geom_n_r1c1");
        addVec(194, 231, 1'b1, "geom_n_r1c2");
        addVec(320, 240, 1'b1, "geom_slot4_r10c0");
        addVec(416, 249, 1'b1, "geom_slot7_r19c0");
        addVec(432, 249, 1'b1, "geom_slot7_r19c16");
        addVec(433, 249, 1'b0, "geom_slot7_r19c17");

        reset             = 1'b1;
        bus.enable        = 1'b0;
        bus.frame_start   = 1'b0;
        bus.start_pressed = 1'b0;
        bus.pixel_x       = 10'd0;
        bus.pixel_y       = 10'd0;

        repeat (3) @(negedge clock_25);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_game_start", 32'(bus.game_start), 32'd0);
        checkOutput("reset_pixel_on", 32'(bus.pixel_on), 32'd0);
        checkOutput("reset_selected_letter", 32'(bus.selected_letter), 32'd0);

        reset      = 1'b0;
        bus.enable = 1'b1;
        repeat (2) @(negedge clock_25);
        checkOutput("enable_busy", 32'(bus.busy), 32'd1);
        applyStimulus(192, 230, 1'b0, "rev0_n_hidden");
        applyStimulus(224, 230, 1'b0, "rev0_e_hidden");
        drainScoreboard();

        pulseFrame(4);
        applyStimulus(192, 230, 1'b1, "rev2_n_origin");
        applyStimulus(256, 230, 1'b0, "rev2_w_hidden");
        applyStimulus(224, 230, 1'b1, "rev2_e_origin");
        drainScoreboard();

        @(negedge clock_25);
        bus.pixel_x = 10'd288;
        bus.pixel_y = 10'd230;
        @(negedge clock_25);
        checkOutput("selected_letter_slot3", 32'(bus.selected_letter), 32'd3);
        bus.pixel_x = 10'd212;
        @(negedge clock_25);
        checkOutput("selected_letter_hold_gap", 32'(bus.selected_letter), 32'd3);

        pulseFrame(12);
        checkOutput("all_revealed_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < geomVec.size(); i++)
            applyStimulus(geomVec[i].x, geomVec[i].y, geomVec[i].exp, geomVec[i].name);
        drainScoreboard();

        pulseFrame(3);
        applyStimulus(192, 230, 1'b0, "blink_off");
        drainScoreboard();
        pulseFrame(3);
        applyStimulus(192, 230, 1'b1, "blink_on_again");
        drainScoreboard();

        @(negedge clock_25);
        bus.start_pressed = 1'b1;
        @(negedge clock_25);
        checkOutput("handoff_game_start", 32'(bus.game_start), 32'd1);
        checkOutput("handoff_idle_busy", 32'(bus.busy), 32'd0);
        bus.enable = 1'b0;
        @(negedge clock_25);
        checkOutput("handoff_pulse_one_cycle", 32'(bus.game_start), 32'd0);

        bus.enable = 1'b1;
        repeat (3) @(negedge clock_25);
        checkOutput("held_start_reveal_busy", 32'(bus.busy), 32'd1);
        applyStimulus(192, 230, 1'b0, "held_start_no_skip");
        drainScoreboard();
        @(negedge clock_25);
        bus.start_pressed = 1'b0;
        @(negedge clock_25);
        bus.start_pressed = 1'b1;
        sawGameStart = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock_25);
            sawGameStart = sawGameStart | bus.game_start;
        end
        checkOutput("held_skip_no_game_start", 32'(sawGameStart), 32'd0);
        checkOutput("skip_blink_busy", 32'(bus.busy), 32'd1);
        applyStimulus(416, 249, 1'b1, "skip_revealed_all");
        drainScoreboard();

        @(negedge clock_25);
        bus.start_pressed = 1'b0;
        bus.enable        = 1'b0;
        @(negedge clock_25);
        bus.enable = 1'b1;
        @(negedge clock_25);
        pulseFrame(1);
        @(negedge clock_25);
        bus.enable        = 1'b0;
        bus.frame_start   = 1'b1;
        bus.start_pressed = 1'b1;
        @(negedge clock_25);
        checkOutput("abort_idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_no_game_start", 32'(bus.game_start), 32'd0);
        bus.frame_start   = 1'b0;
        bus.start_pressed = 1'b0;
        @(negedge clock_25);
        checkOutput("abort_no_game_start_late", 32'(bus.game_start), 32'd0);
        bus.enable = 1'b1;
        @(negedge clock_25);
        pulseFrame(1);
        applyStimulus(192, 230, 1'b0, "abort_counter_cleared");
        drainScoreboard();
        pulseFrame(1);
        applyStimulus(192, 230, 1'b1, "abort_reveal_resumes");
        applyStimulus(224, 230, 1'b0, "abort_e_still_hidden");
        drainScoreboard();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/title_text_sequencer.md
# title_text_sequencer

Drives the 8-entry, 20x20 title glyph ROM ("NEW GAME") from the VGA pixel stream. Maps each pixel coordinate to a letter slot, selects the glyph, extracts the addressed bit and emits a pipelined `pixel_on` for the title-screen mixer. A frame-driven state machine reveals the letters one at a time, blinks the finished title, and hands off to the game on a start press.

## Interface
Parameters:
- `X0`, 192: left pixel column of the text box (slot 0 origin).
- `Y0`, 230: top pixel row of the text box.
- `REVEAL_FRAMES`, 15: frames between successive letter reveals (>=1).
- `BLINK_FRAMES`, 30: frames per blink half-period (>=1).

Ports:
- `clock_25` in 1: pixel clock, 25 MHz. One clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: title screen active.
- `frame_start` in 1: one-cycle pulse per frame, at start of vblank.
- `start_pressed` in 1: level, debounced start button.
- `pixel_x` in 10: current pixel column, 0..639.
- `pixel_y` in 10: current pixel row, 0..479.
- `selected_letter` out 4: glyph ROM index, 0..7. The ROM registers its output one cycle later.
- `letter_bits` in 400: ROM glyph. Bit `399-(r*20+c)` is row r, col c. 1 means lit.
- `pixel_on` out 1: title pixel lit, registered.
- `game_start` out 1: one-cycle pulse on handoff.
- `busy` out 1: high in REVEAL or BLINK.

## Operation
- Geometry:
  - `relx = pixel_x - X0`, `rely = pixel_y - Y0`, both 10-bit unsigned wrap.
  - The pixel is inside the box when `relx < 256`, `relx[4:0] < 20` and `rely < 20`.
  - Slot `k = relx[7:5]`, col `c = relx[4:0]`, row `r = rely[4:0]`.
  - Pixels in the 12-column gap after each glyph are outside.
- `selected_letter = k` when inside, else it holds its previous value.
- Visibility: slot k is shown when `k < revealed` (revealed 0..8) and `blink_vis = 1`.
- `pixel_on = inside_d2 & visible_d2 & letter_bits[399-(r_d2*20+c_d2)]`.
- Slot 3 is the blank glyph. It still consumes a reveal step.
- FSM states: IDLE, REVEAL, BLINK.
  - IDLE: `revealed = 0`, `blink_vis = 1`, `pixel_on = 0`.
    - Go to REVEAL on the cycle `enable = 1`. Both counters clear.
  - REVEAL: on each `frame_start`, the frame counter increments. When it reaches `REVEAL_FRAMES`, the counter clears and `revealed` increments.
    - When `revealed` becomes 8, go to BLINK and clear the counter.
  - BLINK: toggle `blink_vis` every `BLINK_FRAMES` frame_starts.
- Start handling:
  - `start_pressed` in REVEAL sets `revealed = 8` and goes to BLINK with `blink_vis = 1`.
  - `start_pressed` in BLINK pulses `game_start` for one cycle and goes to IDLE.
  - The start press must be edge-detected internally (rising edge). A held button therefore cannot both skip the reveal and start the game.
- Priority, highest first: `reset` > `enable = 0` (go to IDLE next cycle, no `game_start`) > start edge > `frame_start`.
- A `frame_start` coinciding with a start edge is ignored for counting.

## Timing
- Reset values:
  - `selected_letter = 0`, `pixel_on = 0`, `game_start = 0`, `busy = 0`.
  - FSM in IDLE, `revealed = 0`, `blink_vis = 1`, counters 0.
- Pixel pipeline latency is 3 cycles: coordinate at cycle n gives `pixel_on` at cycle n+3.
  - Stage 1 registers `selected_letter`, r, c, inside.
  - Stage 2 is the ROM output; r, c, inside are delayed to match.
  - Stage 3 registers `pixel_on`.
- Visibility changes take effect on the cycle after the FSM update. The pixel pipeline is never stalled.
- Reset mid-frame clears every pipeline stage.
- `game_start` is high exactly one cycle, the cycle after the start edge is sampled.
- Reveal of all 8 letters completes after `8*REVEAL_FRAMES` frame_starts following entry to REVEAL.

## Structure
- Package `title_pkg`:
  - state enum (IDLE, REVEAL, BLINK);
  - `GLYPH_W = 20`, `GLYPH_H = 20`, `PITCH_LOG2 = 5`, `NUM_LETTERS = 8`, `BOX_W = 256`.
- Sub-module `frame_tick_counter`:
  - parameter `N`; inputs `clear`, `frame_start`;
  - output `tick` pulses when N frame_starts have been counted, then self-clears.
  - Instantiated twice: reveal and blink.
- Top level holds geometry decode, the 3-stage pipeline, the FSM and the start edge detector.

## Test plan
- Reset and enable: reset, then `enable = 1` for 2 cycles.
  - FSM reaches REVEAL, `busy = 1`, `pixel_on = 0` everywhere (`revealed = 0`).
- Reveal with `REVEAL_FRAMES = 2`: after 4 frame_starts, `revealed = 2`.
  - Pixel (192,230), slot 0 row 0 col 0 of "N" (bit 399 = 1): `pixel_on = 1` at +3 cycles.
  - Pixel (256,230), slot 2 "W", still hidden: `pixel_on = 0`.
- Geometry edges with all letters revealed:
  - (211,230), col 19 of "N": bit 380 = 0, so `pixel_on = 0`.
  - (212,230), gap: `pixel_on = 0`.
  - (448,230), `relx = 256`: outside.
  - (192,250), `rely = 20`: outside.
  - (191,230) wraps to `relx = 1023`: outside.
- Skip and blink with `BLINK_FRAMES = 3`:
  - Start edge during REVEAL gives `revealed = 8` in BLINK.
  - After 3 frame_starts, `blink_vis = 0` and `pixel_on = 0` at (192,230).
  - After 3 more, lit again.
- Handoff: start edge in BLINK gives a `game_start` pulse of exactly 1 cycle, then IDLE with `busy = 0`.
  - Holding `start_pressed` high through the skip gives no `game_start`.
- Abort: deassert `enable` mid-REVEAL together with `frame_start` and a start edge.
  - Next cycle is IDLE, `game_start` stays 0, counters are 0.
